// File: rtl/holosynth_audio_out.sv
// holosynth_audio_out: Avalon-MM playback slave that queues stereo pairs in a FIFO
// and serializes them as an I2S transmitter timed by the codec bclk/lrck.
// Optional feature macro: HOLOSYNTH_AUDIO_OUT_IRQ_EN enables the low-water
// interrupt together with the CTRL irq_en and threshold fields.
module holosynth_audio_out #(
    parameter int ADDRESS_WIDTH = 3,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_WIDTH    = 6,
    parameter int AUD_BIT_DEPTH = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] slave_address,
    input  logic                     slave_read,
    input  logic                     slave_write,
    input  logic                     slave_chipselect,
    input  logic [DATA_WIDTH-1:0]    slave_writedata,
    output logic [DATA_WIDTH-1:0]    slave_readdata,
    output logic                     slave_irq,
    input  logic                     con_bclk,
    input  logic                     con_lrck,
    output logic                     con_dacdat
);

    localparam int DEPTH   = 1 << FIFO_WIDTH;
    localparam int LEVEL_W = FIFO_WIDTH + 1;
    localparam int PAIR_W  = 2 * AUD_BIT_DEPTH;
    localparam int CNT_W   = $clog2(AUD_BIT_DEPTH + 1);

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_CTRL   = ADDRESS_WIDTH'(0);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_STATUS = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LEFT   = ADDRESS_WIDTH'(2);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_RIGHT  = ADDRESS_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_L,
        ST_SHIFT_L,
        ST_SHIFT_R
    } state_t;

    state_t                     state;

    logic                       bus_wr;
    logic                       bus_rd;
    logic                       wr_ctrl;
    logic                       wr_status;
    logic                       wr_left;
    logic                       wr_right;

    logic                       ctrl_run;
    logic                       ctrl_irq_en;
    logic [7:0]                 ctrl_threshold;
    logic [AUD_BIT_DEPTH-1:0]   left_hold;

    logic                       underrun;
    logic                       overflow;

    logic [PAIR_W-1:0]          fifo_mem [DEPTH];
    logic [FIFO_WIDTH-1:0]      wr_ptr;
    logic [FIFO_WIDTH-1:0]      rd_ptr;
    logic [LEVEL_W-1:0]         level;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic [PAIR_W-1:0]          fifo_head;

    logic                       bclk_meta;
    logic                       bclk_sync;
    logic                       bclk_prev;
    logic                       lrck_meta;
    logic                       lrck_sync;
    logic                       lrck_prev;
    logic                       bclk_fall;
    logic                       lrck_fall;
    logic                       lrck_rise;

    logic                       frame_start;
    logic                       underrun_set;
    logic [AUD_BIT_DEPTH-1:0]   shift_reg;
    logic [AUD_BIT_DEPTH-1:0]   right_word;
    logic [CNT_W-1:0]           bits_left;

    logic [DATA_WIDTH-1:0]      ctrl_word;
    logic [DATA_WIDTH-1:0]      status_word;
    logic                       unused_bits;

    assign bus_wr    = slave_write & slave_chipselect;
    assign bus_rd    = slave_read & slave_chipselect;
    assign wr_ctrl   = bus_wr && (slave_address == ADDR_CTRL);
    assign wr_status = bus_wr && (slave_address == ADDR_STATUS);
    assign wr_left   = bus_wr && (slave_address == ADDR_LEFT);
    assign wr_right  = bus_wr && (slave_address == ADDR_RIGHT);

    assign fifo_full  = (level == LEVEL_W'(DEPTH));
    assign fifo_empty = (level == '0);
    assign fifo_push  = wr_right & ~fifo_full;
    assign fifo_head  = fifo_mem[rd_ptr];

    assign bclk_fall = bclk_prev & ~bclk_sync;
    assign lrck_fall = lrck_prev & ~lrck_sync;
    assign lrck_rise = ~lrck_prev & lrck_sync;

    // A left word starts on lrck falling while armed or after a right word;
    // an empty FIFO at that moment plays silence and flags underrun.
    assign frame_start  = ctrl_run & lrck_fall & ((state == ST_WAIT_L) || (state == ST_SHIFT_R));
    assign fifo_pop     = frame_start & ~fifo_empty;
    assign underrun_set = frame_start & fifo_empty;

    assign unused_bits = &{1'b0, slave_writedata};

    // Codec clocks are asynchronous: two flops for metastability, one more for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_meta <= 1'b0;
            bclk_sync <= 1'b0;
            bclk_prev <= 1'b0;
            lrck_meta <= 1'b0;
            lrck_sync <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            bclk_meta <= con_bclk;
            bclk_sync <= bclk_meta;
            bclk_prev <= bclk_sync;
            lrck_meta <= con_lrck;
            lrck_sync <= lrck_meta;
            lrck_prev <= lrck_sync;
        end
    end

    // Run bit and the left holding register written from the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_run  <= 1'b0;
            left_hold <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_run <= slave_writedata[0];
            end
            if (wr_left) begin
                left_hold <= slave_writedata[AUD_BIT_DEPTH-1:0];
            end
        end
    end

`ifdef HOLOSYNTH_AUDIO_OUT_IRQ_EN
    localparam int CMP_W = (LEVEL_W > 8) ? LEVEL_W : 8;

    // Interrupt enable and low-water threshold fields of CTRL.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_irq_en    <= 1'b0;
            ctrl_threshold <= '0;
        end else if (wr_ctrl) begin
            ctrl_irq_en    <= slave_writedata[1];
            ctrl_threshold <= slave_writedata[15:8];
        end
    end

    // Low-water interrupt, registered so it follows the level by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            slave_irq <= 1'b0;
        end else begin
            slave_irq <= ctrl_irq_en & ctrl_run & (CMP_W'(level) <= CMP_W'(ctrl_threshold));
        end
    end
`else
    assign ctrl_irq_en    = 1'b0;
    assign ctrl_threshold = '0;
    assign slave_irq      = 1'b0;
`endif

    // Sticky status flags; a simultaneous new event wins over a write-one-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_status && slave_writedata[16]) begin
                underrun <= 1'b0;
            end
            if (underrun_set) begin
                underrun <= 1'b1;
            end
            if (wr_status && slave_writedata[18]) begin
                overflow <= 1'b0;
            end
            if (wr_right && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage has no reset; only the pointers and level define its contents.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= {left_hold, slave_writedata[AUD_BIT_DEPTH-1:0]};
        end
    end

    // FIFO pointers and occupancy; a push and pop together leave the level alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (fifo_push && !fifo_pop) begin
                level <= level + 1'b1;
            end else if (!fifo_push && fifo_pop) begin
                level <= level - 1'b1;
            end
        end
    end

    // I2S transmitter: loads a word on each lrck edge and shifts MSB first on bclk falling edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            right_word <= '0;
            bits_left  <= '0;
            con_dacdat <= 1'b0;
        end else if (!ctrl_run) begin
            state      <= ST_IDLE;
            bits_left  <= '0;
            con_dacdat <= 1'b0;
        end else if (frame_start) begin
            shift_reg  <= fifo_pop ? fifo_head[PAIR_W-1:AUD_BIT_DEPTH] : '0;
            right_word <= fifo_pop ? fifo_head[AUD_BIT_DEPTH-1:0] : '0;
            bits_left  <= CNT_W'(AUD_BIT_DEPTH);
            state      <= ST_SHIFT_L;
        end else begin
            case (state)
                ST_IDLE: begin
                    con_dacdat <= 1'b0;
                    state      <= ST_WAIT_L;
                end
                ST_WAIT_L: begin
                    con_dacdat <= 1'b0;
                end
                ST_SHIFT_L: begin
                    if (lrck_rise) begin
                        shift_reg <= right_word;
                        bits_left <= CNT_W'(AUD_BIT_DEPTH);
                        state     <= ST_SHIFT_R;
                    end else if (bclk_fall) begin
                        if (bits_left != '0) begin
                            con_dacdat <= shift_reg[AUD_BIT_DEPTH-1];
                            shift_reg  <= {shift_reg[AUD_BIT_DEPTH-2:0], 1'b0};
                            bits_left  <= bits_left - 1'b1;
                        end else begin
                            con_dacdat <= 1'b0;
                        end
                    end
                end
                ST_SHIFT_R: begin
                    if (bclk_fall) begin
                        if (bits_left != '0) begin
                            con_dacdat <= shift_reg[AUD_BIT_DEPTH-1];
                            shift_reg  <= {shift_reg[AUD_BIT_DEPTH-2:0], 1'b0};
                            bits_left  <= bits_left - 1'b1;
                        end else begin
                            con_dacdat <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Register images as seen by the bus; unused bits read as zero.
    always_comb begin
        ctrl_word                    = '0;
        ctrl_word[0]                 = ctrl_run;
        ctrl_word[1]                 = ctrl_irq_en;
        ctrl_word[15:8]              = ctrl_threshold;
        status_word                  = '0;
        status_word[LEVEL_W-1:0]     = level;
        status_word[16]              = underrun;
        status_word[17]              = fifo_full;
        status_word[18]              = overflow;
    end

    // Registered read data with one cycle of latency; idle cycles return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            slave_readdata <= '0;
        end else if (bus_rd) begin
            case (slave_address)
                ADDR_CTRL:   slave_readdata <= ctrl_word;
                ADDR_STATUS: slave_readdata <= status_word;
                default:     slave_readdata <= '0;
            endcase
        end else begin
            slave_readdata <= '0;
        end
    end

endmodule

// File: tb/tb_holosynth_audio_out.sv
// tb_holosynth_audio_out: drives the bus and the codec clocks, and compares every
// played I2S slot and register read against a queue-based playback model.
module tb_holosynth_audio_out;

    localparam int DEPTH        = 64;
    localparam int NORMAL_HALF  = 80;
    localparam int NORMAL_SLOT  = 32;
    localparam int SHORT_HALF   = 40;
    localparam int SHORT_SLOT   = 26;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  slave_address;
    logic        slave_read;
    logic        slave_write;
    logic        slave_chipselect;
    logic [31:0] slave_writedata;
    logic [31:0] slave_readdata;
    logic        slave_irq;
    logic        con_bclk;
    logic        con_lrck;
    logic        con_dacdat;

    int          n_checks = 0;
    int          n_errors = 0;

    // Behavioural model: queued pairs plus the sticky flags and run bit.
    logic [47:0] pair_q[$];
    logic [23:0] model_left;
    logic        model_run;
    logic        model_underrun;
    logic        model_overflow;

    holosynth_audio_out dut (
        .clk              (clk),
        .reset            (reset),
        .slave_address    (slave_address),
        .slave_read       (slave_read),
        .slave_write      (slave_write),
        .slave_chipselect (slave_chipselect),
        .slave_writedata  (slave_writedata),
        .slave_readdata   (slave_readdata),
        .slave_irq        (slave_irq),
        .con_bclk         (con_bclk),
        .con_lrck         (con_lrck),
        .con_dacdat       (con_dacdat)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        pair_q.delete();
        model_left     = '0;
        model_run      = 1'b0;
        model_underrun = 1'b0;
        model_overflow = 1'b0;
    endtask

    // Bus write; the model applies the same register semantics at a behavioural level.
    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        step();
        slave_address    = addr;
        slave_writedata  = data;
        slave_write      = 1'b1;
        slave_chipselect = 1'b1;
        step();
        slave_write      = 1'b0;
        slave_chipselect = 1'b0;
        case (addr)
            3'd0: model_run = data[0];
            3'd1: begin
                if (data[16]) model_underrun = 1'b0;
                if (data[18]) model_overflow = 1'b0;
            end
            3'd2: model_left = data[23:0];
            3'd3: begin
                if (pair_q.size() < DEPTH) pair_q.push_back({model_left, data[23:0]});
                else model_overflow = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic read_reg(input logic [2:0] addr, output logic [31:0] data);
        step();
        slave_address    = addr;
        slave_read       = 1'b1;
        slave_chipselect = 1'b1;
        step();
        data             = slave_readdata;
        slave_read       = 1'b0;
        slave_chipselect = 1'b0;
    endtask

    function automatic logic [31:0] expected_status();
        logic [31:0] s;
        s       = '0;
        s[6:0]  = 7'(pair_q.size());
        s[16]   = model_underrun;
        s[17]   = (pair_q.size() == DEPTH);
        s[18]   = model_overflow;
        return s;
    endfunction

    task automatic check_status(input string tag);
        logic [31:0] d;
        read_reg(3'd1, d);
        checkOutput(tag, 64'(d), 64'(expected_status()));
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(3'd2, $urandom);
            applyStimulus(3'd3, $urandom);
        end
    endtask

    // One bclk period: lrck changes with the falling edge, data is sampled on the rising edge.
    task automatic codec_bit(input logic lr, input int half, output logic sample);
        con_bclk = 1'b0;
        con_lrck = lr;
        #half;
        con_bclk = 1'b1;
        sample   = con_dacdat;
        #half;
    endtask

    task automatic play_slot(input logic lr, input int half, input int len, output logic [31:0] slot);
        logic s;
        slot = '0;
        for (int i = 0; i < len; i++) begin
            codec_bit(lr, half, s);
            slot = {slot[30:0], s};
        end
    endtask

    // Samples of a slot: one idle bit, the word MSB first, then zero padding.
    function automatic logic [31:0] slot_image(input logic [23:0] word, input int len);
        logic [31:0] w;
        w = {8'h00, word};
        return w << (len - 25);
    endfunction

    task automatic run_frames(input int n, input int half, input int len, input string tag);
        logic [47:0] p;
        logic [31:0] slot;
        for (int f = 0; f < n; f++) begin
            p = '0;
            if (model_run) begin
                if (pair_q.size() > 0) p = pair_q.pop_front();
                else model_underrun = 1'b1;
            end
            play_slot(1'b0, half, len, slot);
            checkOutput($sformatf("%s left %0d", tag, f), 64'(slot), 64'(slot_image(p[47:24], len)));
            play_slot(1'b1, half, len, slot);
            checkOutput($sformatf("%s right %0d", tag, f), 64'(slot), 64'(slot_image(p[23:0], len)));
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        s;
        logic        acc;
        logic [47:0] p;

        reset            = 1'b1;
        slave_address    = '0;
        slave_read       = 1'b0;
        slave_write      = 1'b0;
        slave_chipselect = 1'b0;
        slave_writedata  = '0;
        con_bclk         = 1'b1;
        con_lrck         = 1'b1;
        model_clear();
        repeat (3) step();
        reset = 1'b0;
        step();

        $display("[TB] reset state");
        checkOutput("reset dacdat", 64'(con_dacdat), 64'(0));
        checkOutput("reset irq", 64'(slave_irq), 64'(0));
        checkOutput("reset readdata", 64'(slave_readdata), 64'(0));
        read_reg(3'd1, d);
        checkOutput("reset status", 64'(d), 64'(32'h0000_0000));
        read_reg(3'd0, d);
        checkOutput("reset ctrl", 64'(d), 64'(32'h0000_0000));
        read_reg(3'd5, d);
        checkOutput("unmapped read", 64'(d), 64'(0));

        $display("[TB] directed pair playback");
        applyStimulus(3'd2, 32'h00A5_A5A5);
        applyStimulus(3'd3, 32'h003C_3C3C);
        check_status("level after push");
        applyStimulus(3'd0, 32'h0000_0001);
        run_frames(1, NORMAL_HALF, NORMAL_SLOT, "directed");
        check_status("level after pop");

        $display("[TB] underrun");
        run_frames(2, NORMAL_HALF, NORMAL_SLOT, "underrun");
        check_status("underrun set");
        applyStimulus(3'd1, 32'h0001_0000);
        check_status("underrun cleared");
        applyStimulus(3'd0, 32'h0000_0000);

        $display("[TB] random playback");
        push_random(3);
        applyStimulus(3'd0, 32'h0000_0001);
        run_frames(3, SHORT_HALF, SHORT_SLOT, "random");
        check_status("random drained");

        $display("[TB] run cleared mid word");
        applyStimulus(3'd2, 32'h00FF_FFFF);
        applyStimulus(3'd3, $urandom);
        push_random(1);
        for (int i = 0; i < 10; i++) codec_bit(1'b0, NORMAL_HALF, s);
        p = pair_q.pop_front();
        checkOutput("pre-stop dacdat", 64'(con_dacdat), 64'(p[47]));
        applyStimulus(3'd0, 32'h0000_0000);
        step();
        checkOutput("stop dacdat", 64'(con_dacdat), 64'(0));
        check_status("stop level kept");
        acc = 1'b0;
        for (int i = 0; i < 22; i++) begin codec_bit(1'b0, NORMAL_HALF, s); acc |= s; end
        for (int i = 0; i < 32; i++) begin codec_bit(1'b1, NORMAL_HALF, s); acc |= s; end
        checkOutput("stopped silence", 64'(acc), 64'(0));
        applyStimulus(3'd0, 32'h0000_0001);
        run_frames(1, NORMAL_HALF, NORMAL_SLOT, "restart");
        check_status("restart drained");
        applyStimulus(3'd0, 32'h0000_0000);

        $display("[TB] overflow");
        push_random(65);
        check_status("full overflow");
        applyStimulus(3'd1, 32'h0004_0000);
        check_status("overflow cleared");
        applyStimulus(3'd0, 32'h0000_0001);
        run_frames(65, SHORT_HALF, SHORT_SLOT, "drain");
        check_status("drain underrun");
        applyStimulus(3'd1, 32'h0001_0000);
        applyStimulus(3'd0, 32'h0000_0000);

`ifdef HOLOSYNTH_AUDIO_OUT_IRQ_EN
        $display("[TB] low-water interrupt");
        push_random(6);
        applyStimulus(3'd0, 32'h0000_0403);
        read_reg(3'd0, d);
        checkOutput("ctrl readback", 64'(d), 64'(32'h0000_0403));
        checkOutput("irq level 6", 64'(slave_irq), 64'(0));
        run_frames(1, SHORT_HALF, SHORT_SLOT, "irq");
        step();
        checkOutput("irq level 5", 64'(slave_irq), 64'(0));
        run_frames(1, SHORT_HALF, SHORT_SLOT, "irq");
        step();
        checkOutput("irq level 4", 64'(slave_irq), 64'(1));
        push_random(1);
        checkOutput("irq lag", 64'(slave_irq), 64'(1));
        step();
        checkOutput("irq cleared", 64'(slave_irq), 64'(0));
        check_status("irq level");
        applyStimulus(3'd0, 32'h0000_0000);
`else
        $display("[TB] interrupt disabled build");
        applyStimulus(3'd0, 32'h0000_FF03);
        read_reg(3'd0, d);
        checkOutput("ctrl readback", 64'(d), 64'(32'h0000_0001));
        step();
        checkOutput("irq tied", 64'(slave_irq), 64'(0));
        applyStimulus(3'd0, 32'h0000_0000);
`endif

        $display("[TB] reset mid frame");
        applyStimulus(3'd2, 32'h00FF_FFFF);
        applyStimulus(3'd3, $urandom);
        applyStimulus(3'd0, 32'h0000_0001);
        for (int i = 0; i < 5; i++) codec_bit(1'b0, SHORT_HALF, s);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_clear();
        checkOutput("mid reset dacdat", 64'(con_dacdat), 64'(0));
        check_status("mid reset status");
        read_reg(3'd0, d);
        checkOutput("mid reset ctrl", 64'(d), 64'(0));
        push_random(1);
        applyStimulus(3'd0, 32'h0000_0001);
        acc = 1'b0;
        for (int i = 0; i < SHORT_SLOT - 5; i++) begin codec_bit(1'b0, SHORT_HALF, s); acc |= s; end
        for (int i = 0; i < SHORT_SLOT; i++) begin codec_bit(1'b1, SHORT_HALF, s); acc |= s; end
        checkOutput("wait for left", 64'(acc), 64'(0));
        run_frames(1, SHORT_HALF, SHORT_SLOT, "post reset");
        check_status("post reset drained");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/holosynth_audio_out.md
# holosynth_audio_out

Playback counterpart of the audio capture path: an Avalon-MM slave that accepts stereo samples from the HPS, buffers them in a stereo-pair FIFO, and serializes them as an I2S transmitter. Bit and word timing come from the codec clock domain (`con_bclk`, `con_lrck`). The block sits beside the capture slave on the lightweight bridge and drives the codec DAC data pin.

## Interface
- `ADDRESS_WIDTH`, 3: slave address width.
- `DATA_WIDTH`, 32: slave data width.
- `FIFO_WIDTH`, 6: log2 of FIFO depth in stereo pairs (64 pairs).
- `AUD_BIT_DEPTH`, 24: bits per channel.

- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high reset.
- `slave_address` in ADDRESS_WIDTH: register select.
- `slave_read` in 1: read strobe.
- `slave_write` in 1: write strobe.
- `slave_chipselect` in 1: qualifies read and write.
- `slave_writedata` in DATA_WIDTH: write data.
- `slave_readdata` out DATA_WIDTH: registered read data.
- `slave_irq` out 1: low-water interrupt.
- `con_bclk` in 1: codec bit clock, asynchronous to `clk`.
- `con_lrck` in 1: codec word clock, asynchronous to `clk`; low selects the left channel.
- `con_dacdat` out 1: I2S serial data.

## Operation
- **Register map** (word address):
  - 0 CTRL, read/write: bit0 `run`; bit1 `irq_en`; bits[15:8] `threshold`.
  - 1 STATUS, read: [FIFO_WIDTH:0] `level`; bit16 `underrun`; bit17 `full`; bit18 `overflow`. Writing 1 to bit16 or bit18 clears that bit.
  - 2 LEFT, write: `writedata[AUD_BIT_DEPTH-1:0]` goes to the left holding register.
  - 3 RIGHT, write: pushes {left_hold, `writedata[AUD_BIT_DEPTH-1:0]`} into the FIFO.
- Writes to the RIGHT register while `full` is set are dropped and set `overflow`.
- Unmapped addresses read 0; writes to them are ignored.
- Accesses with `slave_chipselect` low are ignored.
- **FIFO**: 2^FIFO_WIDTH entries, each 2×AUD_BIT_DEPTH bits wide.
  - `level` ranges 0 to 2^FIFO_WIDTH.
  - A push and a pop in the same cycle leave `level` unchanged.
- **Input synchronization**: `con_bclk` and `con_lrck` each pass through a 2-flop synchronizer plus one edge-detect flop.
- **State machine**:
  - IDLE: `con_dacdat`=0. Go to WAIT_L when `run`=1.
  - WAIT_L: wait for a falling edge of `con_lrck`, so playback always starts on a left word.
  - On each `con_lrck` falling edge: pop one pair if the FIFO is not empty, otherwise load zeros and set `underrun`. Load the left word into the shifter and go to SHIFT_L.
  - SHIFT_L: on each `con_bclk` falling edge, drive the next bit, MSB first. This gives the standard I2S one-bit delay after the `con_lrck` edge. After AUD_BIT_DEPTH bits, drive 0. On a `con_lrck` rising edge, load the right word of the same pair and go to SHIFT_R.
  - SHIFT_R: shifts the same way. A `con_lrck` falling edge pops the next pair and returns to SHIFT_L.
  - `run` cleared in any state: go to IDLE on the next cycle and drive `con_dacdat`=0. FIFO contents are kept.
- A `con_lrck` edge arriving before all AUD_BIT_DEPTH bits are shifted truncates the word; the new word loads anyway.

## Timing
- Reset values:
  - `slave_readdata`=0, `slave_irq`=0, `con_dacdat`=0.
  - CTRL=0, holding register=0.
  - FIFO empty, all sticky flags 0, state IDLE.
- Read latency is 1: `slave_readdata` is valid on the cycle after `slave_read`&`slave_chipselect`.
- Writes take effect on the cycle after the strobe. `level` reflects a push one cycle after the RIGHT write.
- Codec edge to action is 3 `clk` cycles.
  - Required: `clk` ≥ 8× `con_bclk` frequency.
  - `con_dacdat` changes 3 `clk` cycles after a `con_bclk` falling edge, well before the next rising edge.
- A pop takes 1 cycle. The popped pair's left MSB appears on the first `con_bclk` falling edge after the `con_lrck` falling edge.
- A `reset` asserted mid-frame clears everything on that clock edge. Output resumes only on a full left word after `run` is set again.

## Configuration
- `HOLOSYNTH_AUDIO_OUT_IRQ_EN` defined:
  - `slave_irq` is registered: it equals `irq_en` & (`level` ≤ `threshold`) & `run`.
  - It deasserts one cycle after the condition clears.
- Macro not defined:
  - `slave_irq` is tied to 0.
  - CTRL bit1 and bits[15:8] read back 0; writes to them are ignored.

## Test plan
- Reset, then read STATUS -> 0x00000000; `con_dacdat`=0; `slave_irq`=0.
- Write LEFT=0xA5A5A5, RIGHT=0x3C3C3C, CTRL=1, then run I2S clocks (bclk=clk/16, 64 bclk per frame) -> left word 0xA5A5A5 shifted MSB first starting one bclk after lrck falls, then 0x3C3C3C; STATUS `level` 1→0.
- `run`=1 with an empty FIFO for 2 frames -> `con_dacdat` stays 0 and `underrun`=1; writing 1 to STATUS bit16 clears it.
- Push 65 pairs with `run`=0 -> `level`=64, `full`=1, `overflow`=1; the 65th pair is never played.
- With the IRQ macro defined, CTRL = `threshold` 4, `irq_en`=1, `run`=1, and 6 pairs queued -> `slave_irq` rises after the second pop (`level` 4). Pushing 1 pair deasserts it 1 cycle later.
- Clear `run` mid left word -> `con_dacdat`=0 within 1 cycle and `level` is unchanged. Setting `run` again -> output restarts at the next lrck falling edge.
